// File: rtl/gates_truth_checker_if.sv
// Signal bundle between the truth checker, the gate block under test and the
// controlling bench/top.
interface gates_truth_checker_if;
  logic       start;
  logic [6:0] gate_o;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [6:0] fail_mask;

  modport slave (
    input  start, gate_o,
    output a, b, busy, done, pass, err_count, fail_mask
  );

  modport master (
    output start, gate_o,
    input  a, b, busy, done, pass, err_count, fail_mask
  );
endinterface

// File: rtl/gates_truth_checker.sv
// Walks the gate block through a/b = 00,01,10,11, lets each vector settle, and
// compares the seven gate outputs against the ideal truth table.
module gates_truth_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gates_truth_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic             a_q;
  logic             b_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [2:0]       err_q;
  logic [6:0]       mask_q;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;

  logic [6:0]       expected;
  logic [6:0]       mismatch;
  logic [2:0]       err_next;
  logic [1:0]       idx_next;

  // a/b are registered copies of idx, so the expected word is derived from them.
  always_comb begin
    expected = {~(a_q ^ b_q), ~(a_q | b_q), ~(a_q & b_q), a_q ^ b_q,
                ~a_q, a_q | b_q, a_q & b_q};
    mismatch = bus.gate_o ^ expected;
    err_next = err_q + {2'b00, |mismatch};
    idx_next = idx + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      mask_q <= '0;
      idx    <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            err_q  <= '0;
            mask_q <= '0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            idx    <= '0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          mask_q <= mask_q | mismatch;
          err_q  <= err_next;
          if (idx == 2'd3) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_next == 3'd0);
            state  <= DONE;
          end else begin
            idx   <= idx_next;
            a_q   <= idx_next[1];
            b_q   <= idx_next[0];
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_mask = mask_q;

endmodule

// File: tb/tb_gates_truth_checker.sv
// Bench for gates_truth_checker: two instances (settle 2 and settle 1) driven by a
// truth-table gate model with injectable faults and settle-time glitches.
module tb_gates_truth_checker;

  localparam int S0 = 2;
  localparam int S1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gates_truth_checker_if if0 ();
  gates_truth_checker_if if1 ();

  gates_truth_checker #(.SETTLE_CYCLES(S0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  gates_truth_checker #(.SETTLE_CYCLES(S1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  int checks = 0;
  int failures = 0;

  // Truth tables indexed by {a,b}: bit k of each entry is the output for vector k.
  logic [3:0] tt [7];
  logic [6:0] corrupt [2][4];
  logic       and_stuck [2];
  logic [6:0] glitch [2];

  function automatic logic [6:0] ideal(input logic [1:0] ab);
    logic [6:0] r;
    for (int g = 0; g < 7; g++) r[g] = tt[g][ab];
    return r;
  endfunction

  function automatic logic [6:0] faulty(input int s, input logic [1:0] ab);
    logic [6:0] r;
    r = ideal(ab) ^ corrupt[s][ab];
    if (and_stuck[s]) r[0] = 1'b0;
    return r;
  endfunction

  always_comb if0.gate_o = faulty(0, {if0.a, if0.b}) ^ glitch[0];
  always_comb if1.gate_o = faulty(1, {if1.a, if1.b}) ^ glitch[1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) if0.start = v; else if1.start = v;
  endtask

  task automatic sample(input int s, output logic [1:0] ab, output logic bz,
                        output logic dn, output logic ps, output logic [2:0] ec,
                        output logic [6:0] fm);
    if (s == 0) begin
      ab = {if0.a, if0.b}; bz = if0.busy; dn = if0.done; ps = if0.pass;
      ec = if0.err_count; fm = if0.fail_mask;
    end else begin
      ab = {if1.a, if1.b}; bz = if1.busy; dn = if1.done; ps = if1.pass;
      ec = if1.err_count; fm = if1.fail_mask;
    end
  endtask

  // One full run from IDLE/DONE; called #1 after a rising edge.
  task automatic run(input int s, input int busy_start_at, input bit use_glitch);
    int S, L;
    logic [1:0] ab; logic bz, dn, ps; logic [2:0] ec; logic [6:0] fm;
    int exp_err; logic [6:0] exp_mask, mm;
    S = (s == 0) ? S0 : S1;
    L = 4 * (S + 1);
    exp_err = 0; exp_mask = '0;
    for (int v = 0; v < 4; v++) begin
      mm = faulty(s, 2'(v)) ^ ideal(2'(v));
      if (mm != 0) exp_err++;
      exp_mask |= mm;
    end
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    for (int n = 0; n <= L; n++) begin
      sample(s, ab, bz, dn, ps, ec, fm);
      chk("ab_seq", 32'(ab), (n < L) ? 32'(n / (S + 1)) : 32'd3);
      chk("busy", 32'(bz), (n < L) ? 32'd1 : 32'd0);
      chk("done", 32'(dn), (n == L) ? 32'd1 : 32'd0);
      if (n == 0) begin
        chk("err_clear", 32'(ec), 32'd0);
        chk("mask_clear", 32'(fm), 32'd0);
        chk("pass_clear", 32'(ps), 32'd0);
      end
      if (n == L) begin
        chk("err_count", 32'(ec), 32'(exp_err));
        chk("fail_mask", 32'(fm), 32'(exp_mask));
        chk("pass", 32'(ps), (exp_err == 0) ? 32'd1 : 32'd0);
      end
      // Corrupt gate_o only during settle periods; the check period stays clean.
      glitch[s] = (use_glitch && n < L && (n % (S + 1)) != S) ? 7'($urandom_range(1, 127)) : '0;
      set_start(s, (n + 1 == busy_start_at) ? 1'b1 : 1'b0);
      if (n < L) begin
        @(posedge clk); #1;
      end
    end
    set_start(s, 1'b0);
    glitch[s] = '0;
  endtask

  task automatic clear_faults();
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 4; v++) corrupt[s][v] = '0;
      and_stuck[s] = 1'b0;
      glitch[s] = '0;
    end
  endtask

  initial begin
    logic [1:0] ab; logic bz, dn, ps; logic [2:0] ec; logic [6:0] fm;
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0011; tt[3] = 4'b0110;
    tt[4] = 4'b0111; tt[5] = 4'b0001; tt[6] = 4'b1001;
    clear_faults();
    if0.start = 1'b0;
    if1.start = 1'b0;

    // Reset state
    #12;
    sample(0, ab, bz, dn, ps, ec, fm);
    chk("rst_outputs", {ab, bz, dn, ps, ec, fm}, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Ideal model, start pulse ignored at cycle 5
    run(0, 0, 1'b0);
    run(0, 5, 1'b0);

    // xor inverted on every vector; restart directly from DONE
    for (int v = 0; v < 4; v++) corrupt[0][v] = 7'b0001000;
    run(0, 0, 1'b0);

    // and stuck-at-0
    clear_faults();
    and_stuck[0] = 1'b1;
    run(0, 0, 1'b0);

    // Randomized sparse faults and settle glitches on both instances
    clear_faults();
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < 2; s++)
        for (int v = 0; v < 4; v++)
          corrupt[s][v] = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
      run(r % 2, 0, r[0] ^ r[1]);
    end

    // SETTLE_CYCLES=1: ideal, then glitches only
    clear_faults();
    run(1, 0, 1'b0);
    run(1, 0, 1'b1);

    // Asynchronous reset during the vector 10 settle
    clear_faults();
    for (int v = 0; v < 4; v++) corrupt[0][v] = 7'b0000010;
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    sample(0, ab, bz, dn, ps, ec, fm);
    chk("pre_rst_ab", 32'(ab), 32'd2);
    chk("pre_rst_err", 32'(ec), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    sample(0, ab, bz, dn, ps, ec, fm);
    chk("async_rst0", {ab, bz, dn, ps, ec, fm}, 32'd0);
    sample(1, ab, bz, dn, ps, ec, fm);
    chk("async_rst1", {ab, bz, dn, ps, ec, fm}, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    sample(0, ab, bz, dn, ps, ec, fm);
    chk("no_resume", {ab, bz, dn, ps, ec, fm}, 32'd0);

    // Fresh run after reset still works
    clear_faults();
    run(0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
